// File: rtl/remote_pkg.sv
// rtl/remote_pkg.sv - shared types and constants for the remote arming sequence
package remote_pkg;

    typedef enum logic [1:0] {
        LOW   = 2'd0,
        HIGH  = 2'd1,
        TRAIL = 2'd2,
        ARMED = 2'd3
    } arm_state_t;

    typedef enum logic [1:0] {
        LO  = 2'd0,
        MID = 2'd1,
        HI  = 2'd2
    } sample_class_t;

    localparam logic [7:0] DEF_LOW_THRESH  = 8'd15;
    localparam logic [7:0] DEF_HIGH_THRESH = 8'd240;
    localparam logic [5:0] CNT_MAX         = 6'd63;

    function automatic logic [5:0] cnt_sat_inc(input logic [5:0] c);
        return (c == CNT_MAX) ? c : c + 6'd1;
    endfunction

endpackage

// File: rtl/remote_arm_detector_if.sv
// rtl/remote_arm_detector_if.sv - sample/control/status bundle of the arm detector
interface remote_arm_detector_if;
    logic       sample_valid;
    logic [7:0] channel;
    logic       disarm;
    logic       armed;
    logic       arm_pulse;
    logic       seq_error;
    logic [2:0] state_dbg;

    modport master (
        output sample_valid, channel, disarm,
        input  armed, arm_pulse, seq_error, state_dbg
    );

    modport slave (
        input  sample_valid, channel, disarm,
        output armed, arm_pulse, seq_error, state_dbg
    );
endinterface

// File: rtl/channel_classifier.sv
// rtl/channel_classifier.sv - combinational LO/MID/HI classification of one channel sample
module channel_classifier
    import remote_pkg::*;
(
    input  logic [7:0]    channel,
    input  logic [7:0]    low_thresh,
    input  logic [7:0]    high_thresh,
    output sample_class_t sample_class
);

    // Inclusive thresholds; anything strictly between them is MID.
    always_comb begin
        sample_class = MID;
        if (channel <= low_thresh)
            sample_class = LO;
        else if (channel >= high_thresh)
            sample_class = HI;
    end

endmodule

// File: rtl/remote_arm_detector.sv
// rtl/remote_arm_detector.sv - recognises low-hold / high-hold / low-trail arming pattern
module remote_arm_detector
    import remote_pkg::*;
#(
    parameter int unsigned HOLD_LEN    = 12,
    parameter int unsigned MAX_HOLD    = 24,
    parameter int unsigned TRAIL_LEN   = 4,
    parameter logic [7:0]  LOW_THRESH  = DEF_LOW_THRESH,
    parameter logic [7:0]  HIGH_THRESH = DEF_HIGH_THRESH
)
(
    input  logic                  clock,
    input  logic                  reset_n,
    remote_arm_detector_if.slave  rx
);

    localparam logic [5:0] HOLD_C  = 6'(HOLD_LEN);
    localparam logic [5:0] MAX_C   = 6'(MAX_HOLD);
    localparam logic [5:0] TRAIL_C = 6'(TRAIL_LEN);

    arm_state_t    state;
    logic [5:0]    cnt;
    logic [5:0]    cnt_inc;
    logic          armed_q;
    logic          arm_pulse_q;
    logic          seq_error_q;
    sample_class_t cls;

    channel_classifier u_classifier (
        .channel      (rx.channel),
        .low_thresh   (LOW_THRESH),
        .high_thresh  (HIGH_THRESH),
        .sample_class (cls)
    );

    assign cnt_inc = cnt_sat_inc(cnt);

    // Sequence FSM: disarm overrides everything, otherwise advance only on valid samples.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= LOW;
            cnt         <= 6'd0;
            armed_q     <= 1'b0;
            arm_pulse_q <= 1'b0;
            seq_error_q <= 1'b0;
        end else begin
            arm_pulse_q <= 1'b0;
            seq_error_q <= 1'b0;
            if (rx.disarm) begin
                state   <= LOW;
                cnt     <= 6'd0;
                armed_q <= 1'b0;
            end else if (rx.sample_valid) begin
                case (state)
                    LOW: begin
                        case (cls)
                            LO: cnt <= cnt_inc;
                            HI: begin
                                if (cnt >= HOLD_C) begin
                                    state <= HIGH;
                                    cnt   <= 6'd1;
                                end else begin
                                    cnt <= 6'd0;
                                end
                            end
                            default: cnt <= 6'd0;
                        endcase
                    end
                    HIGH: begin
                        case (cls)
                            HI: begin
                                if (cnt_inc > MAX_C) begin
                                    state       <= LOW;
                                    cnt         <= 6'd0;
                                    seq_error_q <= 1'b1;
                                end else begin
                                    cnt <= cnt_inc;
                                end
                            end
                            LO: begin
                                cnt <= 6'd1;
                                if (cnt >= HOLD_C) begin
                                    if (TRAIL_C == 6'd1) begin
                                        state       <= ARMED;
                                        armed_q     <= 1'b1;
                                        arm_pulse_q <= 1'b1;
                                    end else begin
                                        state <= TRAIL;
                                    end
                                end else begin
                                    // The aborting LO already counts toward a new low hold.
                                    state       <= LOW;
                                    seq_error_q <= 1'b1;
                                end
                            end
                            default: begin
                                state       <= LOW;
                                cnt         <= 6'd0;
                                seq_error_q <= 1'b1;
                            end
                        endcase
                    end
                    TRAIL: begin
                        if (cls == LO) begin
                            cnt <= cnt_inc;
                            if (cnt_inc == TRAIL_C) begin
                                state       <= ARMED;
                                armed_q     <= 1'b1;
                                arm_pulse_q <= 1'b1;
                            end
                        end else begin
                            state       <= LOW;
                            cnt         <= 6'd0;
                            seq_error_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rx.armed     = armed_q;
    assign rx.arm_pulse = arm_pulse_q;
    assign rx.seq_error = seq_error_q;
    assign rx.state_dbg = {1'b0, state};

endmodule

// File: tb/tb_remote_arm_detector.sv
// tb/tb_remote_arm_detector.sv - scoreboard bench for remote_arm_detector
module tb_remote_arm_detector;
    import remote_pkg::*;

    localparam int HOLD  = 12;
    localparam int MAXH  = 24;
    localparam int TRAIL = 4;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    remote_arm_detector_if dif();

    remote_arm_detector #(
        .HOLD_LEN    (HOLD),
        .MAX_HOLD    (MAXH),
        .TRAIL_LEN   (TRAIL),
        .LOW_THRESH  (8'd15),
        .HIGH_THRESH (8'd240)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .rx      (dif.slave)
    );

    typedef struct {
        int armed;
        int arm_pulse;
        int seq_error;
        int state;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    int m_state = 0;
    int m_cnt   = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int inc63(input int c);
        return (c >= 63) ? 63 : c + 1;
    endfunction

    task automatic model_step(input bit v, input int ch, input bit dis, output exp_t e);
        bit lo, hi;
        e.arm_pulse = 0;
        e.seq_error = 0;
        lo = (ch <= 15);
        hi = (ch >= 240);
        if (dis) begin
            m_state = 0;
            m_cnt   = 0;
        end else if (v) begin
            if (m_state == 0) begin
                if (lo) m_cnt = inc63(m_cnt);
                else if (hi && m_cnt >= HOLD) begin m_state = 1; m_cnt = 1; end
                else m_cnt = 0;
            end else if (m_state == 1) begin
                if (hi) begin
                    m_cnt = inc63(m_cnt);
                    if (m_cnt > MAXH) begin m_state = 0; m_cnt = 0; e.seq_error = 1; end
                end else if (lo) begin
                    if (m_cnt >= HOLD) begin m_state = 2; m_cnt = 1; end
                    else begin m_state = 0; m_cnt = 1; e.seq_error = 1; end
                end else begin
                    m_state = 0; m_cnt = 0; e.seq_error = 1;
                end
            end else if (m_state == 2) begin
                if (lo) begin
                    m_cnt = inc63(m_cnt);
                    if (m_cnt == TRAIL) begin m_state = 3; e.arm_pulse = 1; end
                end else begin
                    m_state = 0; m_cnt = 0; e.seq_error = 1;
                end
            end
        end
        e.state = m_state;
        e.armed = (m_state == 3) ? 1 : 0;
    endtask

    task automatic step(input string tag, input bit v, input int ch, input bit dis);
        exp_t e;
        exp_t got_e;
        @(negedge clock);
        dif.sample_valid = v;
        dif.channel      = 8'(ch);
        dif.disarm       = dis;
        model_step(v, ch, dis, e);
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        got_e = exp_q.pop_front();
        check_val({tag, ".armed"},     int'(dif.armed),     got_e.armed);
        check_val({tag, ".arm_pulse"}, int'(dif.arm_pulse), got_e.arm_pulse);
        check_val({tag, ".seq_error"}, int'(dif.seq_error), got_e.seq_error);
        check_val({tag, ".state"},     int'(dif.state_dbg), got_e.state);
    endtask

    task automatic run(input string tag, input int n, input int ch);
        repeat (n) step(tag, 1'b1, ch, 1'b0);
    endtask

    // One valid sample then two idle cycles carrying a value that would break the hold.
    task automatic run_sparse(input string tag, input int n, input int ch);
        repeat (n) begin
            step(tag, 1'b1, ch, 1'b0);
            step(tag, 1'b0, 128, 1'b0);
            step(tag, 1'b0, 128, 1'b0);
        end
    endtask

    task automatic do_disarm(input string tag);
        step(tag, 1'b0, 0, 1'b1);
    endtask

    initial begin
        dif.sample_valid = 1'b0;
        dif.channel      = 8'd0;
        dif.disarm       = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_val("reset.armed",     int'(dif.armed),     0);
        check_val("reset.arm_pulse", int'(dif.arm_pulse), 0);
        check_val("reset.seq_error", int'(dif.seq_error), 0);
        check_val("reset.state",     int'(dif.state_dbg), 0);
        @(negedge clock);
        reset_n = 1'b1;

        // nominal arm, then samples in ARMED are ignored
        run("nom_lo", 15, 0);
        run("nom_hi", 15, 255);
        run("nom_trail", 4, 0);
        run("armed_hold", 5, 255);
        run("armed_mid", 2, 128);

        // disarm together with a valid LO sample
        step("disarm_prio", 1'b1, 0, 1'b1);
        step("disarm_hold", 1'b1, 255, 1'b1);

        // short low hold: HI with cnt<HOLD resets count, no error
        run("short_lo", 5, 0);
        run("short_lo_hi", 15, 255);
        run("short_lo_tail", 20, 0);

        // boundary: exactly HOLD lows arms (after fresh reset of count by MID)
        step("mid_clear", 1'b1, 128, 1'b0);
        run("bnd_lo11", 11, 0);
        run("bnd_hi_early", 1, 255);
        run("bnd_lo12", 12, 0);
        run("bnd_hi12", 12, 255);
        run("bnd_trail", 4, 0);
        do_disarm("dis1");

        // short high: abort leaves cnt=1, 11 more lows complete the hold
        run("sh_lo", 15, 0);
        run("sh_hi", 6, 255);
        run("sh_abort", 1, 0);
        run("sh_lo11", 11, 0);
        run("sh_hi2", 15, 255);
        run("sh_trail", 4, 0);
        do_disarm("dis2");

        // over-long high: exactly MAX_HOLD ok, one more errors
        run("ol_lo", 15, 0);
        run("ol_hi", 25, 255);
        run("ol_lo2", 15, 0);
        run("ol_hi24", 24, 255);
        run("ol_trail1", 1, 0);
        step("trail_mid", 1'b1, 128, 1'b0);
        run("hi_mid_lo", 14, 0);
        run("hi_mid_hi", 3, 255);
        step("high_mid", 1'b1, 200, 1'b0);
        run("trail_hi_lo", 12, 0);
        run("trail_hi_hi", 12, 255);
        run("trail_hi_t", 2, 0);
        step("trail_hi", 1'b1, 250, 1'b0);

        // sparse stimulus still arms
        run_sparse("sp_lo", 13, 0);
        run_sparse("sp_hi", 13, 255);
        run_sparse("sp_trail", 4, 3);
        do_disarm("dis3");

        // asynchronous reset in the middle of HIGH
        run("rst_lo", 15, 0);
        run("rst_hi", 8, 255);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_val("rst_async.armed",     int'(dif.armed),     0);
        check_val("rst_async.arm_pulse", int'(dif.arm_pulse), 0);
        check_val("rst_async.seq_error", int'(dif.seq_error), 0);
        check_val("rst_async.state",     int'(dif.state_dbg), 0);
        m_state = 0;
        m_cnt   = 0;
        @(negedge clock);
        reset_n = 1'b1;
        run("post_rst_hi", 3, 255);
        run("post_rst_lo", 15, 0);
        run("post_rst_hi2", 15, 255);
        run("post_rst_trail", 4, 0);

        check_val("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/remote_arm_detector.md
# remote_arm_detector

Receive-side counterpart of the remote arming sequence. Watches one 8-bit remote channel (throttle) sample stream and recognises the arming pattern: a sustained low hold, a sustained full-scale high hold, then a return to low. When the pattern completes it asserts a sticky `armed` flag. The flag stays set until an explicit disarm, and it gates the motor/command path downstream of the remote interface.

## Interface
- `HOLD_LEN`, 12: minimum consecutive LO samples before HIGH, and minimum consecutive HI samples in HIGH.
- `MAX_HOLD`, 24: maximum consecutive HI samples tolerated in HIGH; must satisfy HOLD_LEN ≤ MAX_HOLD ≤ 63.
- `TRAIL_LEN`, 4: consecutive LO samples after the high hold that are required to arm; 1 ≤ TRAIL_LEN ≤ 63.
- `LOW_THRESH`, 8'd15: a sample ≤ this value classifies as LO.
- `HIGH_THRESH`, 8'd240: a sample ≥ this value classifies as HI; must exceed LOW_THRESH.
- `clock` in 1: single clock; all logic is rising-edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `sample_valid` in 1: qualifies `channel` for one cycle.
- `channel` in 8: remote channel value.
- `disarm` in 1: level input; forces the block out of any state.
- `armed` out 1: sticky armed flag. Reset value 0.
- `arm_pulse` out 1: one-cycle pulse on entry to ARMED. Reset value 0.
- `seq_error` out 1: one-cycle pulse when a partially matched sequence is aborted. Reset value 0.
- `state_dbg` out 3: current state encoding. Reset value LOW.

## Operation
- Each valid sample is classified as exactly one of LO, HI or MID (anything between the two thresholds).
- `cnt` is a 6-bit counter. Every increment saturates at 63.
- Sample-driven transitions, by state:
  - LOW (reset state):
    - LO: cnt++.
    - HI with cnt ≥ HOLD_LEN: go to HIGH, cnt=1.
    - HI with cnt < HOLD_LEN: stay in LOW, cnt=0, no error.
    - MID: cnt=0.
  - HIGH:
    - HI: cnt++. If the new cnt > MAX_HOLD: go to LOW, cnt=0, pulse seq_error.
    - LO with cnt ≥ HOLD_LEN: go to TRAIL, cnt=1. If TRAIL_LEN==1, go straight to ARMED instead.
    - LO with cnt < HOLD_LEN: go to LOW, cnt=1, pulse seq_error.
    - MID: go to LOW, cnt=0, pulse seq_error.
  - TRAIL:
    - LO: cnt++. When the new cnt == TRAIL_LEN: go to ARMED, pulse arm_pulse.
    - HI or MID: go to LOW, cnt=0, pulse seq_error.
  - ARMED: samples are ignored and cnt holds.
- `disarm` high in any state: go to LOW, cnt=0, armed=0, no pulses. Disarm takes priority over a sample in the same cycle. While disarm stays high, samples are ignored.
- No state change when sample_valid=0. Gaps between samples do not break a hold.
- `armed` = (state == ARMED), registered.

## Timing
- All outputs are registered.
- arm_pulse, seq_error and the armed rising edge appear the cycle after the clock edge that samples the completing or aborting input.
- Output latency is 1 cycle from sample to flag.
- armed falls the cycle after disarm is sampled.
- When reset_n is asserted mid-sequence, state, cnt and all outputs clear immediately (asynchronously). The first sample after reset release is evaluated in LOW.
- Back-to-back valid samples every cycle are supported; there is no throughput limit.

## Structure
- Shared package `remote_pkg`:
  - state enum: LOW=0, HIGH=1, TRAIL=2, ARMED=3.
  - sample class enum: LO, MID, HI.
  - default threshold constants 8'd15 and 8'd240, shared with the transmit-side sequencer.
- Sub-module `channel_classifier`: purely combinational. Maps `channel` and the two thresholds to the sample class, and is reusable for other channels.
- The FSM, counter and output registers live in the top module.

## Test plan
- Nominal arm: 15×0, 15×255, 4×0, one sample per cycle → single arm_pulse on the cycle after the 4th trailing 0; armed=1 held; seq_error never asserted.
- Short low: 5×0, 15×255, 20×0 → no arm, no seq_error; state returns to LOW on the first 255 with cnt=0.
- Short high: 15×0, 6×255, 0 → seq_error pulse; state LOW with cnt=1. Follow with 11×0, 15×255, 4×0 → arms.
- Over-long high: 15×0, 25×255 → seq_error on the 25th HI; armed stays 0. Inject MID (128) in TRAIL → seq_error.
- Disarm priority: armed, then disarm=1 together with sample_valid=1 and channel=0 → armed=0 next cycle, state LOW, cnt=0. Sparse stimulus with sample_valid toggling every 3rd cycle → nominal sequence still arms.
- Reset mid-HIGH: reset_n low for 1 cycle after 8×255 → all outputs 0 immediately; full sequence afterwards arms normally.
